// File: rtl/sequence_checker.sv
// ---------------------------------------------------------------------------
// sequence_checker
// Tracks a fixed 7-byte repeating sequence (AF BC E2 78 FF 0B 8D) on a
// qualified byte stream. Reports lock status, one-cycle mismatch and
// period-complete pulses, and saturating period / error counters.
// All outputs are registered: they reflect the byte consumed on the
// preceding rising clock edge.
//
// Configuration macro: SEQ_CHECKER_ERRCNT_EN
//   defined   -> err_count is a saturating mismatch counter
//   undefined -> err_count is tied to zero and no counter register exists
// ---------------------------------------------------------------------------
module sequence_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [7:0]       data_in,
  output logic             locked,
  output logic             mismatch,
  output logic             period_done,
  output logic [CNT_W-1:0] period_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [0:0] {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  localparam logic [7:0]       SYNC_BYTE = 8'hAF;
  localparam logic [2:0]       LAST_IDX  = 3'd6;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Expected byte for a given position in the sequence.
  function automatic logic [7:0] exp_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'hAF;
      3'd1:    b = 8'hBC;
      3'd2:    b = 8'hE2;
      3'd3:    b = 8'h78;
      3'd4:    b = 8'hFF;
      3'd5:    b = 8'h0B;
      3'd6:    b = 8'h8D;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_idx;
  logic [2:0] w_idx_nxt;
  logic       w_mismatch_nxt;
  logic       w_period_done_nxt;

  logic             r_locked;
  logic             r_mismatch;
  logic             r_period_done;
  logic [CNT_W-1:0] r_period_count;

  // Next-state, next-index and pulse decode for the HUNT/LOCKED tracker.
  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_mismatch_nxt    = 1'b0;
    w_period_done_nxt = 1'b0;
    if (enable) begin
      case (r_state)
        S_HUNT: begin
          if (data_in == SYNC_BYTE) begin
            w_state_nxt = S_LOCKED;
            w_idx_nxt   = 3'd1;
          end else begin
            w_state_nxt = S_HUNT;
            w_idx_nxt   = 3'd0;
          end
        end
        S_LOCKED: begin
          if (data_in == exp_byte(r_idx)) begin
            // A sync byte at idx 0 lands here as an ordinary match.
            if (r_idx == LAST_IDX) begin
              w_idx_nxt         = 3'd0;
              w_period_done_nxt = 1'b1;
            end else begin
              w_idx_nxt = r_idx + 3'd1;
            end
          end else begin
            w_mismatch_nxt = 1'b1;
            if (data_in == SYNC_BYTE) begin
              // Out-of-place sync byte: re-align immediately.
              w_state_nxt = S_LOCKED;
              w_idx_nxt   = 3'd1;
            end else begin
              w_state_nxt = S_HUNT;
              w_idx_nxt   = 3'd0;
            end
          end
        end
        default: begin
          w_state_nxt = S_HUNT;
          w_idx_nxt   = 3'd0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
    end
  end

  // State, index and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_HUNT;
      r_idx         <= 3'd0;
      r_locked      <= 1'b0;
      r_mismatch    <= 1'b0;
      r_period_done <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_locked      <= (w_state_nxt == S_LOCKED);
      r_mismatch    <= w_mismatch_nxt;
      r_period_done <= w_period_done_nxt;
    end
  end

  // Saturating count of completed periods.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_period_count <= {CNT_W{1'b0}};
    end else if (w_period_done_nxt && (r_period_count != CNT_MAX)) begin
      r_period_count <= r_period_count + CNT_ONE;
    end else begin
      r_period_count <= r_period_count;
    end
  end

`ifdef SEQ_CHECKER_ERRCNT_EN
  logic [CNT_W-1:0] r_err_count;

  // Saturating count of mismatches; the pulse itself is unaffected by saturation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_err_count <= {CNT_W{1'b0}};
    end else if (w_mismatch_nxt && (r_err_count != CNT_MAX)) begin
      r_err_count <= r_err_count + CNT_ONE;
    end else begin
      r_err_count <= r_err_count;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = {CNT_W{1'b0}};
`endif

  assign locked       = r_locked;
  assign mismatch     = r_mismatch;
  assign period_done  = r_period_done;
  assign period_count = r_period_count;

endmodule
